// File: rtl/mips_wbuf.sv
// mips_wbuf: posted-store write buffer for the MIPS I core.
// Queues word-aligned stores from the MEM stage and drains them to the
// external bus through a BREQ/BACK handshake. It also flags loads that
// target a word with a pending store.
// Optional feature: define MIPS_WBUF_MERGE_EN to enable store merging into
// the tail-most entry. This also adds the `merged` output.
module mips_wbuf #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  we,
  input  logic [31:0] DA,
  input  logic [31:0] DO,
  input  logic        re,
  output logic        full,
  output logic        hazard,
  output logic        empty,
  output logic [31:0] BA,
  output logic [31:0] BD,
  output logic [3:0]  BWE,
  output logic        BREQ,
  input  logic        BACK
`ifdef MIPS_WBUF_MERGE_EN
  ,
  output logic        merged
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [29:0]    addr_q [DEPTH];
  logic [31:0]    data_q [DEPTH];
  logic [3:0]     mask_q [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  count;
  logic [DEPTH-1:0] valid;
  logic           push;
  logic           pop;
  logic           merge_hit;
  logic           addr_hit;
  logic           unused_da;

  // The low address bits are ignored because every store is word-aligned.
  assign unused_da = ^DA[1:0];

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign BREQ  = !empty;
  assign pop   = BREQ && BACK;

`ifdef MIPS_WBUF_MERGE_EN
  logic [PW-1:0] last;
  assign last      = tail - PW'(1);
  // The head entry is never merged into because the bus is presenting it,
  // so merging needs at least two entries.
  assign merge_hit = (we != 4'b0) && (count >= CW'(2)) && (addr_q[last] == DA[31:2]);
  assign merged    = merge_hit;
`else
  assign merge_hit = 1'b0;
`endif

  // A merge consumes the store, so it never allocates a new entry.
  assign push = (we != 4'b0) && !full && !merge_hit;

  // The bus side always shows the head slot. Freed slots are zeroed, so an
  // empty buffer presents all zeros.
  assign BA  = {addr_q[head], 2'b00};
  assign BD  = data_q[head];
  assign BWE = mask_q[head];

  // Mark the slots lying between head and head+count as occupied.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = ({1'b0, PW'(i) - head} < count);
    end
  end

  // Compare the load address against every occupied slot.
  always_comb begin
    addr_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (addr_q[i] == DA[31:2])) begin
        addr_hit = 1'b1;
      end
    end
    hazard = re && addr_hit;
  end

  // Write, merge and free the entry storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[tail] <= DA[31:2];
        data_q[tail] <= DO;
        mask_q[tail] <= we;
      end
`ifdef MIPS_WBUF_MERGE_EN
      if (merge_hit) begin
        for (int k = 0; k < 4; k++) begin
          if (we[k]) begin
            data_q[last][8*k +: 8] <= DO[8*k +: 8];
          end
        end
        mask_q[last] <= mask_q[last] | we;
      end
`endif
      if (pop) begin
        addr_q[head] <= '0;
        data_q[head] <= '0;
        mask_q[head] <= '0;
      end
    end
  end

  // Advance the pointers and track the occupancy count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mips_wbuf.sv
// tb_mips_wbuf: scoreboard bench for mips_wbuf.
// Stimulus runs the directed test plan and then a random phase. A monitor
// checks the outputs every cycle against a queue-based model.
module tb_mips_wbuf;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } ent_t;

  logic        clock;
  logic        reset;
  logic [3:0]  we;
  logic [31:0] DA;
  logic [31:0] DO;
  logic        re;
  logic        full;
  logic        hazard;
  logic        empty;
  logic [31:0] BA;
  logic [31:0] BD;
  logic [3:0]  BWE;
  logic        BREQ;
  logic        BACK;
`ifdef MIPS_WBUF_MERGE_EN
  logic        merged;
`endif

  int   checks;
  int   errors;
  ent_t q[$];
  ent_t nxt;
  bit   nxt_push;
  bit   nxt_merge;
  bit   exp_merge;

  mips_wbuf #(.DEPTH(DEPTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .we     (we),
    .DA     (DA),
    .DO     (DO),
    .re     (re),
    .full   (full),
    .hazard (hazard),
    .empty  (empty),
    .BA     (BA),
    .BD     (BD),
    .BWE    (BWE),
    .BREQ   (BREQ),
    .BACK   (BACK)
`ifdef MIPS_WBUF_MERGE_EN
    ,
    .merged (merged)
`endif
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare the DUT against the model state for the current cycle. Then
  // retire the head if the bus handshake completes at the coming edge.
  task automatic checkOutput();
    logic [31:0] eba;
    logic [31:0] ebd;
    logic [3:0]  ebwe;
    bit          ehz;
    eba = '0; ebd = '0; ebwe = '0; ehz = 0;
    if (q.size() != 0) begin
      eba  = {q[0].a, 2'b00};
      ebd  = q[0].d;
      ebwe = q[0].m;
    end
    if (re) begin
      foreach (q[i]) if (q[i].a == DA[31:2]) ehz = 1;
    end
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("breq", BREQ, q.size() != 0);
    chk("hazard", hazard, ehz);
    chk("ba", BA, eba);
    chk("bd", BD, ebd);
    chk("bwe", BWE, ebwe);
`ifdef MIPS_WBUF_MERGE_EN
    chk("merged", merged, exp_merge);
`endif
    if (BACK && q.size() != 0) void'(q.pop_front());
  endtask

  // Monitor: mid-cycle sampling, only while out of reset.
  always @(negedge clock) begin
    if (reset) checkOutput();
  end

  // Drive one cycle of inputs and work out the expected effect on the model.
  task automatic applyStimulus(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                               input logic r, input logic b, output bit accepted);
    we = w; DA = a; DO = d; re = r; BACK = b;
    exp_merge = 0;
`ifdef MIPS_WBUF_MERGE_EN
    if (w != 0 && q.size() >= 2 && q[$].a == a[31:2]) exp_merge = 1;
`endif
    nxt_merge = exp_merge;
    nxt_push  = (w != 0) && !exp_merge && (q.size() < DEPTH);
    nxt       = '{a: a[31:2], d: d, m: w};
    accepted  = nxt_merge || nxt_push;
  endtask

  // Apply the store decided for the edge that just happened to the model.
  task automatic commit();
    ent_t t;
    if (nxt_merge && q.size() != 0) begin
      t = q[$];
      for (int k = 0; k < 4; k++) if (nxt.m[k]) t.d[8*k +: 8] = nxt.d[8*k +: 8];
      t.m = t.m | nxt.m;
      q[q.size()-1] = t;
    end else if (nxt_push) begin
      q.push_back(nxt);
    end
    nxt_merge = 0;
    nxt_push  = 0;
  endtask

  task automatic cycle(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                       input logic r, input logic b, output bit accepted);
    applyStimulus(w, a, d, r, b, accepted);
    @(posedge clock);
    commit();
    #1;
  endtask

  task automatic drain();
    bit acc;
    for (int n = 0; n < 40 && q.size() != 0; n++) cycle(4'h0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    chk("drain_empty", empty, 1'b1);
    chk("drain_model", q.size(), 0);
  endtask

  initial begin
    bit          acc;
    bit          have;
    logic [3:0]  sw;
    logic [31:0] sa;
    logic [31:0] sd;
    logic [31:0] ra;
    checks = 0; errors = 0;
    nxt_push = 0; nxt_merge = 0; exp_merge = 0;
    reset = 1'b0; we = 0; DA = 0; DO = 0; re = 0; BACK = 0;
    #3;
    chk("rst_full", full, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_breq", BREQ, 1'b0);
    chk("rst_hazard", hazard, 1'b0);
    chk("rst_ba", BA, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Single store, followed by one bus transfer.
    cycle(4'hF, 32'h1000, 32'hAABBCCDD, 1'b0, 1'b0, acc);
    chk("single_breq", BREQ, 1'b1);
    chk("single_ba", BA, 32'h1000);
    chk("single_bd", BD, 32'hAABBCCDD);
    chk("single_bwe", BWE, 4'hF);
    cycle(4'h0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    chk("single_empty", empty, 1'b1);
    chk("single_breq0", BREQ, 1'b0);

    // Fill the buffer to full, hold a fifth store, then drain in order.
    for (int i = 0; i < 4; i++) cycle(4'hF, 32'(4 * i), 32'h100 + 32'(i), 1'b0, 1'b0, acc);
    chk("fill_full", full, 1'b1);
    have = 1;
    for (int n = 0; n < 10 && have; n++) begin
      cycle(4'hF, 32'h10, 32'h104, 1'b0, 1'b1, acc);
      if (acc) have = 0;
    end
    chk("fill_fifth_accepted", have, 1'b0);
    drain();

    // A pending store to the load's word raises hazard until it drains.
    cycle(4'h3, 32'h20, 32'h1234, 1'b0, 1'b0, acc);
    cycle(4'hC, 32'h24, 32'h5678, 1'b0, 1'b0, acc);
    cycle(4'h0, 32'h24, 32'h0, 1'b1, 1'b0, acc);
    chk("hazard_hit", hazard, 1'b1);
    cycle(4'h0, 32'h28, 32'h0, 1'b1, 1'b0, acc);
    chk("hazard_miss", hazard, 1'b0);
    for (int n = 0; n < 4; n++) cycle(4'h0, 32'h24, 32'h0, 1'b1, 1'b1, acc);
    chk("hazard_cleared", hazard, 1'b0);
    drain();

    // Stores to the same word: merged when enabled, separate otherwise.
    cycle(4'h1, 32'h40, 32'h11, 1'b0, 1'b0, acc);
    cycle(4'h1, 32'h44, 32'h22, 1'b0, 1'b0, acc);
    cycle(4'h2, 32'h44, 32'h3300, 1'b0, 1'b0, acc);
`ifdef MIPS_WBUF_MERGE_EN
    chk("merge_entries", q.size(), 2);
`else
    chk("nomerge_entries", q.size(), 3);
`endif
    drain();

    // Random traffic over a small address set, so hazards and merges occur.
    have = 0; sw = 0; sa = 0; sd = 0;
    for (int n = 0; n < 400; n++) begin
      if (!have && ($urandom_range(0, 1) == 1)) begin
        have = 1;
        sw = 4'($urandom_range(1, 15));
        sa = 32'h100 + 32'(4 * $urandom_range(0, 5));
        sd = $urandom;
      end
      ra = 32'h100 + 32'(4 * $urandom_range(0, 5));
      cycle(have ? sw : 4'h0, have ? sa : ra, sd, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) != 0), acc);
      if (have && acc) have = 0;
    end
    drain();

    // Reset in the middle of a drain discards pending entries at once.
    for (int i = 0; i < 3; i++) cycle(4'hF, 32'h200 + 32'(4 * i), $urandom, 1'b0, 1'b0, acc);
    chk("midrst_breq_before", BREQ, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    chk("midrst_breq", BREQ, 1'b0);
    chk("midrst_empty", empty, 1'b1);
    chk("midrst_full", full, 1'b0);
    chk("midrst_ba", BA, 32'h0);
    chk("midrst_bd", BD, 32'h0);
    chk("midrst_bwe", BWE, 4'h0);
    for (int n = 0; n < 2; n++) cycle(4'h0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    reset = 1'b1;
    for (int n = 0; n < 3; n++) cycle(4'h0, 32'h200, 32'h0, 1'b1, 1'b1, acc);
    chk("postrst_empty", empty, 1'b1);
    chk("postrst_ba", BA, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
